// File: rtl/add_pipe_pkg.sv
// Shared constants and configuration helpers for the segmented pipelined adder.
package add_pipe_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SEG   = 8;

  // Number of pipeline stages for a given operand width and segment width.
  // A non-positive segment width maps to 1 so the division stays defined;
  // the configuration check in the top rejects it separately.
  function automatic int stages_of(input int width, input int seg);
    if (seg < 1) return 1;
    return width / seg;
  endfunction

  // True when the operand splits into a whole number of non-empty segments.
  function automatic bit seg_cfg_ok(input int width, input int seg);
    if (seg < 1) return 1'b0;
    if (width < seg) return 1'b0;
    return (width % seg) == 0;
  endfunction

endpackage

// File: rtl/add_pipe_nb_if.sv
// Operand/result bundle for add_pipe_nb.
// Handshake: a word moves across a channel on a rising clock edge where its
// valid and ready are both high; a producer holds valid and data stable until
// that edge, and ready may depend combinationally on the downstream ready.
interface add_pipe_nb_if #(
  parameter int WIDTH = add_pipe_pkg::DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cy;
  logic             ovf;

  // Operand producer / result consumer side
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cy, ovf
  );

  // Adder side
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cy, ovf
  );

endinterface

// File: rtl/add_pipe_stage.sv
// One registered SEG-bit slice of the pipelined adder: adds its operand
// segments plus the incoming carry and registers sum, carry and valid.
// Everything holds while i_en is low so the whole pipeline stalls together.
module add_pipe_stage #(
  parameter int SEG = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_en,
  input  logic           i_valid,
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_cin,
  output logic           o_valid,
  output logic [SEG-1:0] o_s,
  output logic           o_cy
);

  logic           valid_d, valid_q;
  logic           cy_d, cy_q;
  logic [SEG-1:0] s_d, s_q;

  // Slice add when the pipeline advances, otherwise hold
  always_comb begin
    valid_d = valid_q;
    cy_d    = cy_q;
    s_d     = s_q;
    if (i_en) begin
      valid_d      = i_valid;
      {cy_d, s_d}  = {1'b0, i_a} + {1'b0, i_b} + {{SEG{1'b0}}, i_cin};
    end
  end

  // Slice registers, cleared asynchronously
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      cy_q    <= 1'b0;
      s_q     <= '0;
    end else begin
      valid_q <= valid_d;
      cy_q    <= cy_d;
      s_q     <= s_d;
    end
  end

  assign o_valid = valid_q;
  assign o_s     = s_q;
  assign o_cy    = cy_q;

endmodule

// File: rtl/add_pipe_nb.sv
// Segmented pipelined adder/subtractor with valid/ready handshake.
// Stage k adds segment k using the registered carry of stage k-1. Operands
// are skewed alongside the slices so each stage sees its own segment, and the
// finished low segments ride forward to line up with the final carry.
// A single global enable (o_ready) stalls every stage at once.
module add_pipe_nb
  import add_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_s,
  output logic             o_cy,
  output logic             o_ovf
);

  localparam int STAGES = stages_of(WIDTH, SEG);

  if (!seg_cfg_ok(WIDTH, SEG)) begin : g_bad_cfg
    $error("add_pipe_nb: WIDTH must be a whole multiple of SEG and SEG >= 1");
  end

  logic             en;
  logic [WIDTH-1:0] a_in, b_in;
  logic             c_in;

  // Index k holds the operand as seen by stage k; index STAGES is aligned
  // with the outputs and supplies the sign bits for overflow.
  logic [WIDTH-1:0] a_d [1:STAGES];
  logic [WIDTH-1:0] a_q [1:STAGES];
  logic [WIDTH-1:0] b_d [1:STAGES];
  logic [WIDTH-1:0] b_q [1:STAGES];

  // res_q[k] holds sum segments 0..k-2 of the op currently in stage k-1;
  // full[k] merges in the segment registered by stage k-1.
  logic [WIDTH-1:0] res_d [1:STAGES];
  logic [WIDTH-1:0] res_q [1:STAGES];
  logic [WIDTH-1:0] full  [1:STAGES];

  logic [SEG-1:0]    seg_s [STAGES];
  logic [STAGES-1:0] seg_cy;
  logic [STAGES-1:0] seg_v;

  assign en      = ~o_valid | i_ready;
  assign o_ready = en;

  // Subtract is A + ~B + 1; carry-in is ignored then
  assign a_in = i_a;
  assign b_in = i_sub ? ~i_b : i_b;
  assign c_in = i_sub ? 1'b1 : i_cin;

  // Operand skew: shift one stage per advance, hold on stall
  always_comb begin
    for (int k = 1; k <= STAGES; k++) begin
      a_d[k] = a_q[k];
      b_d[k] = b_q[k];
    end
    if (en) begin
      a_d[1] = a_in;
      b_d[1] = b_in;
      for (int k = 2; k <= STAGES; k++) begin
        a_d[k] = a_q[k-1];
        b_d[k] = b_q[k-1];
      end
    end
  end

  // Partial result view after each stage: carried-forward low bits plus the new slice
  always_comb begin
    for (int k = 1; k <= STAGES; k++) begin
      full[k] = res_q[k] | (WIDTH'(seg_s[k-1]) << ((k-1) * SEG));
    end
  end

  // Result alignment: completed low segments advance with their operation
  always_comb begin
    for (int k = 1; k <= STAGES; k++) begin
      res_d[k] = res_q[k];
    end
    if (en) begin
      res_d[1] = '0;
      for (int k = 2; k <= STAGES; k++) begin
        res_d[k] = full[k-1];
      end
    end
  end

  // Skew and alignment registers, cleared asynchronously
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 1; k <= STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
      end
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        res_q[k] <= res_d[k];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG-1:0] a_seg;
    logic [SEG-1:0] b_seg;
    logic           cin_k;
    logic           v_in;

    if (k == 0) begin : g_first
      assign a_seg = a_in[SEG-1:0];
      assign b_seg = b_in[SEG-1:0];
      assign cin_k = c_in;
      assign v_in  = i_valid;
    end else begin : g_next
      assign a_seg = a_q[k][k*SEG +: SEG];
      assign b_seg = b_q[k][k*SEG +: SEG];
      assign cin_k = seg_cy[k-1];
      assign v_in  = seg_v[k-1];
    end

    add_pipe_stage #(.SEG(SEG)) u_stage (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_en    (en),
      .i_valid (v_in),
      .i_a     (a_seg),
      .i_b     (b_seg),
      .i_cin   (cin_k),
      .o_valid (seg_v[k]),
      .o_s     (seg_s[k]),
      .o_cy    (seg_cy[k])
    );
  end

  assign o_valid = seg_v[STAGES-1];
  assign o_cy    = seg_cy[STAGES-1];
  assign o_s     = full[STAGES];
  assign o_ovf   = (a_q[STAGES][WIDTH-1] == b_q[STAGES][WIDTH-1]) &
                   (full[STAGES][WIDTH-1] != a_q[STAGES][WIDTH-1]);

endmodule

// File: tb/tb_add_pipe_nb.sv
// Bench for add_pipe_nb: main instance (SEG=8) with random backpressure,
// plus SEG=4 and SEG=32 instances fed the same accepted operations.
module tb_add_pipe_nb;
  import add_pipe_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  add_pipe_nb_if #(.WIDTH(W)) bus ();

  add_pipe_nb #(.WIDTH(W), .SEG(8)) u_dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (bus.in_valid),
    .o_ready (bus.in_ready),
    .i_a     (bus.a),
    .i_b     (bus.b),
    .i_cin   (bus.cin),
    .i_sub   (bus.sub),
    .o_valid (bus.out_valid),
    .i_ready (bus.out_ready),
    .o_s     (bus.s),
    .o_cy    (bus.cy),
    .o_ovf   (bus.ovf)
  );

  logic         x_valid;
  logic         r4, v4, cy4, ovf4;
  logic         r32, v32, cy32, ovf32;
  logic [W-1:0] s4, s32;

  assign x_valid = bus.in_valid & bus.in_ready;

  add_pipe_nb #(.WIDTH(W), .SEG(4)) u_dut4 (
    .i_clk (clk), .i_rst (rst), .i_valid (x_valid), .o_ready (r4),
    .i_a (bus.a), .i_b (bus.b), .i_cin (bus.cin), .i_sub (bus.sub),
    .o_valid (v4), .i_ready (1'b1), .o_s (s4), .o_cy (cy4), .o_ovf (ovf4)
  );

  add_pipe_nb #(.WIDTH(W), .SEG(32)) u_dut32 (
    .i_clk (clk), .i_rst (rst), .i_valid (x_valid), .o_ready (r32),
    .i_a (bus.a), .i_b (bus.b), .i_cin (bus.cin), .i_sub (bus.sub),
    .o_valid (v32), .i_ready (1'b1), .o_s (s32), .o_cy (cy32), .o_ovf (ovf32)
  );

  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  int           in_cyc  = 0;
  int           out_cyc [3];
  logic [W+1:0] exp_q [3][$];
  logic [W+1:0] cur_exp;

  // Reference: {ovf, cy, s}
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   sum;
    logic         ovf;
    bb  = sub ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    ovf = (a[W-1] == bb[W-1]) && (sum[W-1] != a[W-1]);
    return {ovf, sum};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic out_check(input int k, input logic v, input logic rdy, input logic [W+1:0] got);
    if (v && rdy) begin
      n_tests++;
      assert (exp_q[k].size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_out dut%0d observed=%0h expected=none", k, got);
      end
      if (exp_q[k].size() != 0) chk($sformatf("result dut%0d", k), got, exp_q[k].pop_front());
      out_cyc[k] = cyc;
    end else if (v && exp_q[k].size() != 0) begin
      chk($sformatf("held dut%0d", k), got, exp_q[k][0]);
    end
  endtask

  // One clock: sample away from the edge, score, then step past the edge
  task automatic tick(output bit acc);
    @(negedge clk);
    chk("o_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
    out_check(0, bus.out_valid, bus.out_ready, {bus.ovf, bus.cy, bus.s});
    out_check(1, v4, 1'b1, {ovf4, cy4, s4});
    out_check(2, v32, 1'b1, {ovf32, cy32, s32});
    acc = bus.in_valid && bus.in_ready;
    if (acc) begin
      in_cyc = cyc;
      for (int k = 0; k < 3; k++) exp_q[k].push_back(cur_exp);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic sub, input logic [W+1:0] exp, input bit rand_rdy);
    bit acc;
    acc          = 1'b0;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.sub      = sub;
    bus.in_valid = 1'b1;
    cur_exp      = exp;
    for (int i = 0; i < 50; i++) begin
      if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
      tick(acc);
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", acc, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_rand(input bit rand_rdy);
    logic [W-1:0] a, b;
    logic         cin, sub;
    a   = $urandom;
    b   = ($urandom_range(0, 7) == 0) ? ~a : $urandom;
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
    send(a, b, cin, sub, model(a, b, cin, sub), rand_rdy);
  endtask

  task automatic idle(input int n, input bit rand_rdy);
    bit acc;
    for (int i = 0; i < n; i++) begin
      if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
      tick(acc);
    end
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 400; i++) begin
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) break;
      bus.out_ready = 1'($urandom_range(0, 1));
      tick(acc);
    end
    chk("drain_left", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
  endtask

  task automatic latency_check(input string tag);
    for (int k = 0; k < 3; k++) out_cyc[k] = -1;
    bus.out_ready = 1'b1;
    send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b0, 32'h0000_0100}, 1'b0);
    idle(10, 1'b0);
    chk({tag, "_seg8"},  out_cyc[0] - in_cyc, 4);
    chk({tag, "_seg4"},  out_cyc[1] - in_cyc, 8);
    chk({tag, "_seg32"}, out_cyc[2] - in_cyc, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    cur_exp       = '0;

    // Reset state
    #1;
    chk("rst_o_valid", bus.out_valid, 0);
    chk("rst_o_s", bus.s, 0);
    chk("rst_o_cy", bus.cy, 0);
    chk("rst_o_ovf", bus.ovf, 0);
    chk("rst_o_ready", bus.in_ready, 1);
    chk("rst_valid_seg4", v4, 0);
    chk("rst_valid_seg32", v32, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Latency per configuration, carry across a segment boundary
    latency_check("lat");

    // Directed corner cases, back to back
    bus.out_ready = 1'b1;
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, {1'b0, 1'b1, 32'h0000_0000}, 1'b0);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000_0000}, 1'b0);
    send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE}, 1'b0);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF}, 1'b0);
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0000_0000}, 1'b0);
    send(32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, {1'b0, 1'b1, 32'h0000_0007}, 1'b0);
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, {1'b1, 1'b1, 32'h0000_0000}, 1'b0);
    idle(10, 1'b0);

    // Held output under sustained backpressure
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_rand(1'b0);
    idle(6, 1'b0);
    drain();

    // Random traffic with random downstream ready
    for (int i = 0; i < 100; i++) send_rand(1'b1);
    drain();

    // Reset mid-stream discards everything in flight
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) send_rand(1'b0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_o_valid", bus.out_valid, 0);
    chk("midrst_o_s", bus.s, 0);
    chk("midrst_o_ready", bus.in_ready, 1);
    chk("midrst_valid_seg4", v4, 0);
    chk("midrst_valid_seg32", v32, 0);
    for (int k = 0; k < 3; k++) exp_q[k].delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(12, 1'b1);
    latency_check("postrst");
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
